bbox_detect: RTL and testbench



---
 rtl/bbox_detect_if.sv | 24 ++
 rtl/bbox_detect.sv | 165 ++++++++++++++++
 tb/tb_bbox_detect.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/bbox_detect_if.sv
// rtl/bbox_detect_if.sv - control, frame-memory read and result bundle for bbox_detect
interface bbox_detect_if;
  logic        start;
  logic        done;
  logic        busy;
  logic [9:0]  threshold;
  logic [31:0] readAddr;
  logic [15:0] readdata;
  logic [10:0] xMin;
  logic [10:0] xMax;
  logic [10:0] yMin;
  logic [10:0] yMax;
  logic        found;

  modport master (
    output start, threshold, readdata,
    input  done, busy, readAddr, xMin, xMax, yMin, yMax, found
  );

  modport slave (
    input  start, threshold, readdata,
    output done, busy, readAddr, xMin, xMax, yMin, yMax, found
  );
endinterface

// File: rtl/bbox_detect.sv
// rtl/bbox_detect.sv - foreground bounding-box scanner over a raw bottom-up BGR frame
// Seven cycles per pixel (REQ/CAP per channel, then EVAL); result committed on the last EVAL.
module bbox_detect #(
  parameter int WIDTH  = 100,
  parameter int HEIGHT = 100
) (
  input logic          clk,
  input logic          rst_n,
  bbox_detect_if.slave bus
);
  typedef enum logic [2:0] {IDLE, REQ, CAP, EVAL, FINISHED} state_t;

  localparam logic [10:0] X_LAST = 11'(WIDTH - 1);
  localparam logic [10:0] Y_LAST = 11'(HEIGHT - 1);

  state_t      state;
  state_t      stateNext;
  logic [10:0] x;
  logic [10:0] y;
  logic [1:0]  c;
  logic [9:0]  sum;
  logic [9:0]  thr;
  logic        runFound;
  logic [10:0] rxMin;
  logic [10:0] rxMax;
  logic [10:0] ryMin;
  logic [10:0] ryMax;
  logic [10:0] xMinQ;
  logic [10:0] xMaxQ;
  logic [10:0] yMinQ;
  logic [10:0] yMaxQ;
  logic        foundQ;
  logic        fg;
  logic        xLast;
  logic        yLast;
  logic        scanning;
  logic        nFound;
  logic [10:0] nxMin;
  logic [10:0] nxMax;
  logic [10:0] nyMin;
  logic [10:0] nyMax;
  logic [31:0] pixAddr;
  logic        unusedHi;

  assign unusedHi = ^bus.readdata[15:8];

  assign xLast    = (x == X_LAST);
  assign yLast    = (y == Y_LAST);
  assign fg       = (sum < thr);
  assign scanning = (state == REQ) || (state == CAP) || (state == EVAL);

  // Frame is stored bottom-up, so top-down row y lives at stored row HEIGHT-1-y.
  assign pixAddr = ((32'(HEIGHT - 1) - 32'(y)) * 32'(WIDTH) + 32'(x)) * 32'd3 + 32'(c);

  assign bus.readAddr = scanning ? pixAddr : 32'd0;
  assign bus.busy     = scanning;
  assign bus.done     = (state == FINISHED);
  assign bus.xMin     = xMinQ;
  assign bus.xMax     = xMaxQ;
  assign bus.yMin     = yMinQ;
  assign bus.yMax     = yMaxQ;
  assign bus.found    = foundQ;

  // Running box including the pixel under evaluation; ryMin never moves once set.
  always_comb begin
    nFound = runFound;
    nxMin  = rxMin;
    nxMax  = rxMax;
    nyMin  = ryMin;
    nyMax  = ryMax;
    if (fg) begin
      nFound = 1'b1;
      if (!runFound) begin
        nxMin = x;
        nxMax = x;
        nyMin = y;
        nyMax = y;
      end else begin
        if (x < rxMin) nxMin = x;
        if (x > rxMax) nxMax = x;
        nyMax = y;
      end
    end
  end

  always_comb begin
    stateNext = state;
    case (state)
      IDLE, FINISHED: if (bus.start) stateNext = REQ;
      REQ:            stateNext = CAP;
      CAP:            stateNext = (c == 2'd2) ? EVAL : REQ;
      EVAL:           stateNext = (xLast && yLast) ? FINISHED : REQ;
      default:        stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= stateNext;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x        <= '0;
      y        <= '0;
      c        <= '0;
      sum      <= '0;
      thr      <= '0;
      runFound <= 1'b0;
      rxMin    <= '0;
      rxMax    <= '0;
      ryMin    <= '0;
      ryMax    <= '0;
      xMinQ    <= '0;
      xMaxQ    <= X_LAST;
      yMinQ    <= '0;
      yMaxQ    <= Y_LAST;
      foundQ   <= 1'b0;
    end else begin
      case (state)
        IDLE, FINISHED: begin
          if (bus.start) begin
            x        <= '0;
            y        <= '0;
            c        <= '0;
            sum      <= '0;
            thr      <= bus.threshold;
            runFound <= 1'b0;
            rxMin    <= '0;
            rxMax    <= '0;
            ryMin    <= '0;
            ryMax    <= '0;
          end
        end
        CAP: begin
          sum <= sum + {2'b00, bus.readdata[7:0]};
          c   <= (c == 2'd2) ? 2'd0 : c + 2'd1;
        end
        EVAL: begin
          runFound <= nFound;
          rxMin    <= nxMin;
          rxMax    <= nxMax;
          ryMin    <= nyMin;
          ryMax    <= nyMax;
          sum      <= '0;
          if (!xLast) begin
            x <= x + 11'd1;
          end else begin
            x <= '0;
            if (!yLast) begin
              y <= y + 11'd1;
            end else begin
              foundQ <= nFound;
              xMinQ  <= nFound ? nxMin : 11'd0;
              xMaxQ  <= nFound ? nxMax : X_LAST;
              yMinQ  <= nFound ? nyMin : 11'd0;
              yMaxQ  <= nFound ? nyMax : Y_LAST;
            end
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_bbox_detect.sv
// tb/tb_bbox_detect.sv - scoreboard bench for bbox_detect on a 10x10 frame
// Stimulus pushes the expected box and done cycle; a monitor pops on each rising done.
module tb_bbox_detect;
  localparam int W      = 10;
  localparam int H      = 10;
  localparam int NPIX   = W * H;
  localparam int NBYTES = NPIX * 3;

  typedef struct {
    logic        found;
    logic [10:0] x0;
    logic [10:0] x1;
    logic [10:0] y0;
    logic [10:0] y1;
    int          doneCyc;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  int         cyc = 0;
  int         total = 0;
  int         bad = 0;
  exp_t       sb[$];
  exp_t       e;
  logic       doneSeen = 1'b0;
  logic [7:0] mem [0:NBYTES-1];

  bbox_detect_if bus();

  bbox_detect #(.WIDTH(W), .HEIGHT(H)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // One-cycle read latency; the upper byte is junk the DUT must ignore.
  always @(posedge clk) begin
    if (bus.readAddr < NBYTES) bus.readdata <= {8'hA5, mem[bus.readAddr]};
    else                       bus.readdata <= 16'hA5EE;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d required %0d", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && bus.done && !doneSeen) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_done: got done=1 at cycle %0d required no pending scan", cyc);
      end else begin
        e = sb.pop_front();
        check("done_cycle", cyc, e.doneCyc);
        check("found", bus.found, e.found);
        check("xMin", bus.xMin, e.x0);
        check("xMax", bus.xMax, e.x1);
        check("yMin", bus.yMin, e.y0);
        check("yMax", bus.yMax, e.y1);
      end
    end
    doneSeen = bus.done;
  end

  task automatic fillWhite();
    for (int i = 0; i < NBYTES; i++) mem[i] = 8'hFF;
  endtask

  task automatic setPix(input int px, input int py, input logic [7:0] b, input logic [7:0] g,
                        input logic [7:0] r);
    int base;
    base = ((H - 1 - py) * W + px) * 3;
    mem[base]     = b;
    mem[base + 1] = g;
    mem[base + 2] = r;
  endtask

  task automatic startScan(input logic [9:0] thr, input logic expFound, input logic [10:0] ex0,
                           input logic [10:0] ex1, input logic [10:0] ey0, input logic [10:0] ey1);
    exp_t x;
    @(negedge clk);
    bus.threshold = thr;
    bus.start     = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    x.found   = expFound;
    x.x0      = ex0;
    x.x1      = ex1;
    x.y0      = ey0;
    x.y1      = ey1;
    x.doneCyc = cyc + 7 * NPIX;
    sb.push_back(x);
    check("busy_after_start", bus.busy, 1);
    check("done_after_start", bus.done, 0);
  endtask

  task automatic waitDone();
    for (int i = 0; i < 7 * NPIX + 20; i++) begin
      @(negedge clk);
      if (bus.done) break;
    end
    check("done_reached", bus.done, 1);
  endtask

  task automatic checkReset();
    check("rst_done", bus.done, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_found", bus.found, 0);
    check("rst_xMin", bus.xMin, 0);
    check("rst_xMax", bus.xMax, W - 1);
    check("rst_yMin", bus.yMin, 0);
    check("rst_yMax", bus.yMax, H - 1);
    check("rst_readAddr", bus.readAddr, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish required finish within time limit");
    $fatal(1);
  end

  initial begin
    bus.start     = 1'b0;
    bus.threshold = 10'd0;
    fillWhite();
    repeat (3) @(negedge clk);
    checkReset();
    rst_n = 1'b1;

    // All white, threshold 300: nothing foreground; check the first two fetch addresses.
    startScan(10'd300, 1'b0, 11'd0, 11'd9, 11'd0, 11'd9);
    check("addr_first", bus.readAddr, 270);
    @(posedge clk); #1;
    check("addr_cap0", bus.readAddr, 270);
    @(posedge clk); #1;
    check("addr_second", bus.readAddr, 271);
    waitDone();

    fillWhite();
    setPix(5, 7, 8'h00, 8'h00, 8'h00);
    startScan(10'd300, 1'b1, 11'd5, 11'd5, 11'd7, 11'd7);
    waitDone();

    fillWhite();
    setPix(0, 0, 8'h00, 8'h00, 8'h00);
    setPix(9, 9, 8'h00, 8'h00, 8'h00);
    startScan(10'd300, 1'b1, 11'd0, 11'd9, 11'd0, 11'd9);
    waitDone();

    fillWhite();
    setPix(3, 2, 8'h00, 8'h00, 8'h00);
    setPix(7, 2, 8'h00, 8'h00, 8'h00);
    setPix(1, 6, 8'h00, 8'h00, 8'h00);
    startScan(10'd300, 1'b1, 11'd1, 11'd7, 11'd2, 11'd6);
    waitDone();

    // Sum exactly 300 sits on the threshold boundary.
    fillWhite();
    setPix(4, 4, 8'd100, 8'd100, 8'd100);
    startScan(10'd300, 1'b0, 11'd0, 11'd9, 11'd0, 11'd9);
    waitDone();
    startScan(10'd301, 1'b1, 11'd4, 11'd4, 11'd4, 11'd4);
    waitDone();

    // Reset mid-scan discards the partial result.
    startScan(10'd301, 1'b1, 11'd4, 11'd4, 11'd4, 11'd4);
    repeat (348) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checkReset();
    sb.delete();
    @(negedge clk);
    rst_n = 1'b1;

    // Fresh scan with a start pulse while busy that must be ignored.
    startScan(10'd301, 1'b1, 11'd4, 11'd4, 11'd4, 11'd4);
    repeat (100) @(negedge clk);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    check("busy_ignores_start", bus.busy, 1);
    waitDone();

    // Restart from FINISHED; threshold changed after start must not matter.
    fillWhite();
    setPix(2, 8, 8'h10, 8'h10, 8'h10);
    setPix(6, 3, 8'h20, 8'h20, 8'h20);
    startScan(10'd200, 1'b1, 11'd2, 11'd6, 11'd3, 11'd8);
    bus.threshold = 10'd0;
    repeat (350) @(posedge clk);
    #1;
    check("held_found", bus.found, 1);
    check("held_xMin", bus.xMin, 4);
    check("held_xMax", bus.xMax, 4);
    check("held_yMin", bus.yMin, 4);
    check("held_yMax", bus.yMax, 4);
    waitDone();

    startScan(10'd0, 1'b0, 11'd0, 11'd9, 11'd0, 11'd9);
    waitDone();

    repeat (3) @(negedge clk);
    check("scoreboard_empty", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
